// File: rtl/ecc_word_sram_pkg.sv
// Shared constants, Hsiao(39,32) column generator and FSM state type
// for the ECC-protected word SRAM bank.
package ecc_word_sram_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned CodeW = 39;
  localparam int unsigned ChkW  = 7;

  typedef enum logic {
    NORMAL = 1'b0,
    RMW    = 1'b1
  } state_e;

  // Column of data bit j: the j-th 7-bit value, in ascending order, with exactly three ones.
  function automatic logic [ChkW-1:0] hsiao_col(input int unsigned j);
    logic [ChkW-1:0] col;
    int unsigned     n;
    col = '0;
    n   = 0;
    for (int unsigned v = 0; v < 128; v++) begin
      if ($countones(v[ChkW-1:0]) == 3) begin
        if (n == j) col = v[ChkW-1:0];
        n++;
      end
    end
    return col;
  endfunction

  // Data bits participating in check bit i; shifted in from the top so bit j lands at position j.
  function automatic logic [DataW-1:0] hsiao_row(input int unsigned i);
    logic [DataW-1:0] row;
    logic [ChkW-1:0]  col;
    row = '0;
    for (int unsigned j = 0; j < DataW; j++) begin
      col = hsiao_col(j);
      row = {|(col & (7'd1 << i)), row[DataW-1:1]};
    end
    return row;
  endfunction

endpackage

// File: rtl/hsiao_39_32_codec.sv
// Combinational Hsiao SECDED encoder plus independent decoder/corrector.
// err = 01 single error (corrected), 10 double/uncorrectable error.
module hsiao_39_32_codec
  import ecc_word_sram_pkg::*;
(
  input  logic [DataW-1:0] enc_data,
  output logic [CodeW-1:0] enc_code,
  input  logic [CodeW-1:0] dec_code,
  output logic [DataW-1:0] dec_data,
  output logic [1:0]       dec_err
);

  logic [ChkW-1:0]  enc_chk;
  logic [ChkW-1:0]  rec_chk;
  logic [ChkW-1:0]  syndrome;
  logic [DataW-1:0] flip;

  for (genvar gi = 0; gi < ChkW; gi++) begin : g_chk
    localparam logic [DataW-1:0] RowMask = hsiao_row(gi);
    assign enc_chk[gi] = ^(enc_data & RowMask);
    assign rec_chk[gi] = ^(dec_code[DataW-1:0] & RowMask);
  end

  assign enc_code = {enc_chk, enc_data};
  assign syndrome = rec_chk ^ dec_code[CodeW-1:DataW];

  // Data columns all have weight 3, so a match can only occur for odd syndromes.
  for (genvar gi = 0; gi < DataW; gi++) begin : g_flip
    localparam logic [ChkW-1:0] Col = hsiao_col(gi);
    assign flip[gi] = (syndrome == Col);
  end

  assign dec_data = dec_code[DataW-1:0] ^ flip;

  always_comb begin
    dec_err = 2'b00;
    if (syndrome != '0) begin
      dec_err = (^syndrome) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ecc_word_sram.sv
// Single-port SECDED-protected SRAM bank behind a TCDM request/grant port.
// Byte-enabled writes become a two-cycle read-modify-write with gnt held low.
module ecc_word_sram
  import ecc_word_sram_pkg::*;
#(
  parameter  int unsigned BankSize     = 256,
  parameter  int unsigned InputECC     = 0,
  localparam int unsigned BankAddWidth = $clog2(BankSize),
  localparam int unsigned DataWidth    = (InputECC != 0) ? CodeW : DataW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tcdm_req_i,
  input  logic                 tcdm_wen_i,
  input  logic [31:0]          tcdm_add_i,
  input  logic [3:0]           tcdm_be_i,
  input  logic [DataWidth-1:0] tcdm_wdata_i,
  output logic                 tcdm_gnt_o,
  output logic [DataWidth-1:0] tcdm_rdata_o,
  output logic                 single_error_o,
  output logic                 multi_error_o
);

  state_e                  state_reg, state_next;
  logic [BankAddWidth-1:0] addr_reg;
  logic [DataWidth-1:0]    wdata_reg;
  logic [3:0]              be_reg;
  logic                    valid_reg;

  logic [CodeW-1:0]        mem [BankSize];
  logic [CodeW-1:0]        rdata_reg;
  logic                    mem_req, mem_we, mem_en;
  logic [BankAddWidth-1:0] mem_addr;
  logic [CodeW-1:0]        mem_wdata;

  logic [CodeW-1:0]        bus_code, merged_code;
  logic [DataW-1:0]        rd_data, new_data, be_mask, merged;
  logic [1:0]              rd_err;
  logic                    partial;
  logic                    unused_addr;

  assign unused_addr = ^{tcdm_add_i[31:BankAddWidth+2], tcdm_add_i[1:0]};
  assign partial     = tcdm_req_i & ~tcdm_wen_i & (tcdm_be_i != 4'b1111);

  always_comb begin
    state_next = state_reg;
    tcdm_gnt_o = 1'b1;
    mem_req    = tcdm_req_i;
    mem_we     = ~tcdm_wen_i & (tcdm_be_i == 4'b1111);
    mem_addr   = tcdm_add_i[BankAddWidth+1:2];
    mem_wdata  = bus_code;
    unique case (state_reg)
      NORMAL: begin
        if (partial) state_next = RMW;
      end
      RMW: begin
        tcdm_gnt_o = 1'b0;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = addr_reg;
        mem_wdata  = merged_code;
        state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  // A reset arriving mid-RMW must not let the merged write reach the array.
  assign mem_en = mem_req & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= NORMAL;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= tcdm_add_i[BankAddWidth+1:2];
      wdata_reg <= tcdm_wdata_i;
      be_reg    <= tcdm_be_i;
      valid_reg <= tcdm_req_i & tcdm_gnt_o & (tcdm_wen_i | (tcdm_be_i != 4'b1111));
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        rdata_reg     <= mem[mem_addr];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_be_mask
    assign be_mask[8*gi +: 8] = {8{be_reg[gi]}};
  end

  assign merged = (be_mask & new_data) | (~be_mask & rd_data);

  hsiao_39_32_codec u_rd_codec (
    .enc_data (merged),
    .enc_code (merged_code),
    .dec_code (rdata_reg),
    .dec_data (rd_data),
    .dec_err  (rd_err)
  );

  if (InputECC == 0) begin : g_plain
    logic [DataW-1:0] unused_dec_data;
    logic [1:0]       unused_dec_err;
    hsiao_39_32_codec u_wr_codec (
      .enc_data (tcdm_wdata_i),
      .enc_code (bus_code),
      .dec_code ('0),
      .dec_data (unused_dec_data),
      .dec_err  (unused_dec_err)
    );
    assign new_data     = wdata_reg;
    assign tcdm_rdata_o = rd_data;
  end else begin : g_coded
    logic [CodeW-1:0] unused_enc_code;
    logic [1:0]       unused_dec_err;
    hsiao_39_32_codec u_wr_codec (
      .enc_data ('0),
      .enc_code (unused_enc_code),
      .dec_code (wdata_reg),
      .dec_data (new_data),
      .dec_err  (unused_dec_err)
    );
    assign bus_code     = tcdm_wdata_i;
    assign tcdm_rdata_o = rdata_reg;
  end

  assign single_error_o = rd_err[0] & valid_reg;
  assign multi_error_o  = rd_err[1] & valid_reg;

endmodule

// File: tb/tb_ecc_word_sram.sv
// Directed bench for ecc_word_sram: vector table on a plain-data bank, then
// hand sequences for error injection, reset during RMW and a codeword-bus bank.
module tb_ecc_word_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wen;
  logic [31:0] add;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;
  logic        se, me;

  logic        req_c, wen_c;
  logic [31:0] add_c;
  logic [3:0]  be_c;
  logic [38:0] wdata_c;
  logic        gnt_c;
  logic [38:0] rdata_c;
  logic        se_c, me_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecc_word_sram #(.BankSize(256), .InputECC(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tcdm_req_i(req), .tcdm_wen_i(wen),
    .tcdm_add_i(add), .tcdm_be_i(be), .tcdm_wdata_i(wdata),
    .tcdm_gnt_o(gnt), .tcdm_rdata_o(rdata),
    .single_error_o(se), .multi_error_o(me)
  );

  ecc_word_sram #(.BankSize(256), .InputECC(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .tcdm_req_i(req_c), .tcdm_wen_i(wen_c),
    .tcdm_add_i(add_c), .tcdm_be_i(be_c), .tcdm_wdata_i(wdata_c),
    .tcdm_gnt_o(gnt_c), .tcdm_rdata_o(rdata_c),
    .single_error_o(se_c), .multi_error_o(me_c)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  // Reference encoder: walk 1..127, keep weight-3 values in order as data columns.
  function automatic logic [38:0] tb_encode(input logic [31:0] d);
    logic [6:0] chk;
    int n, w;
    chk = '0;
    n = 0;
    for (int v = 1; v < 128; v++) begin
      w = 0;
      for (int b = 0; b < 7; b++) w += (v >> b) & 1;
      if (w == 3 && n < 32) begin
        if (d[n]) chk = chk ^ 7'(v);
        n++;
      end
    end
    return {chk, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that completes the access.
  task automatic bus_op(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic g_pre, output logic g_post,
                        output logic [31:0] rd, output logic s, output logic m);
    req = 1'b1; wen = w; add = a; be = b; wdata = d;
    @(negedge clk);
    g_pre = gnt;
    @(posedge clk); #1;
    req = 1'b0; wen = 1'b1; be = 4'hF;
    g_post = gnt; rd = rdata; s = se; m = me;
    $display("txn wen=%b addr=%h be=%h wdata=%h -> rdata=%h se=%b me=%b gnt_next=%b",
             w, a, b, d, rd, s, m, g_post);
    if (!w && b != 4'hF) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_op_c(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [38:0] d, output logic g_post,
                          output logic [38:0] rd, output logic s, output logic m);
    req_c = 1'b1; wen_c = w; add_c = a; be_c = b; wdata_c = d;
    @(posedge clk); #1;
    req_c = 1'b0; wen_c = 1'b1; be_c = 4'hF;
    g_post = gnt_c; rd = rdata_c; s = se_c; m = me_c;
    $display("txn(ecc bus) wen=%b addr=%h be=%h wdata=%h -> rdata=%h se=%b me=%b gnt_next=%b",
             w, a, b, d, rd, s, m, g_post);
    if (!w && b != 4'hF) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic        g_pre, g_post, s, m;
    logic [31:0] rd;
    logic [38:0] rd_c;

    vecs[0]  = '{1'b0, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 32'h010, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h010, 4'h1, 32'h000000AA, 32'h0};
    vecs[3]  = '{1'b1, 32'h010, 4'hF, 32'h0,        32'hDEADBEAA};
    vecs[4]  = '{1'b0, 32'h404, 4'hF, 32'h01234567, 32'h0};
    vecs[5]  = '{1'b1, 32'h004, 4'hF, 32'h0,        32'h01234567};
    vecs[6]  = '{1'b0, 32'h004, 4'h6, 32'h00CAFE00, 32'h0};
    vecs[7]  = '{1'b1, 32'h404, 4'hF, 32'h0,        32'h01CAFE67};
    vecs[8]  = '{1'b0, 32'h010, 4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1'b1, 32'h010, 4'hF, 32'h0,        32'hDEADBEAA};
    vecs[10] = '{1'b0, 32'h3FC, 4'hF, 32'hFFFFFFFF, 32'h0};
    vecs[11] = '{1'b1, 32'hFFC, 4'hF, 32'h0,        32'hFFFFFFFF};
    vecs[12] = '{1'b1, 32'h020, 4'hF, 32'h0,        32'h00000000};

    rst_n = 1'b0;
    req = 1'b0; wen = 1'b1; add = '0; be = 4'hF; wdata = '0;
    req_c = 1'b0; wen_c = 1'b1; add_c = '0; be_c = 4'hF; wdata_c = '0;
    for (int i = 0; i < 256; i++) begin
      dut.mem[i]   = '0;
      dut_c.mem[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset gnt", 64'(gnt), 64'd1);
    check("reset single_error", 64'(se), 64'd0);
    check("reset multi_error", 64'(me), 64'd0);
    check("reset gnt ecc bus", 64'(gnt_c), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      bus_op(vecs[i].wen, vecs[i].addr, vecs[i].be, vecs[i].wdata, g_pre, g_post, rd, s, m);
      check($sformatf("vec%0d gnt", i), 64'(g_pre), 64'd1);
      check($sformatf("vec%0d gnt next", i),
            64'(g_post), 64'(vecs[i].wen || vecs[i].be == 4'hF));
      if (vecs[i].wen) check($sformatf("vec%0d rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d single_error", i), 64'(s), 64'd0);
      check($sformatf("vec%0d multi_error", i), 64'(m), 64'd0);
    end
    check("stored codeword 0x10", 64'(dut.mem[4]), 64'(tb_encode(32'hDEADBEAA)));

    // Single-bit error on stored data bit 5.
    dut.mem[4] = dut.mem[4] ^ 39'h20;
    bus_op(1'b1, 32'h010, 4'hF, 32'h0, g_pre, g_post, rd, s, m);
    check("single rdata", 64'(rd), 64'hDEADBEAA);
    check("single single_error", 64'(s), 64'd1);
    check("single multi_error", 64'(m), 64'd0);
    @(posedge clk); #1;
    check("single flag one cycle", 64'(se), 64'd0);
    dut.mem[4] = dut.mem[4] ^ 39'h20;

    // Double-bit error on stored bits 3 and 20.
    dut.mem[4] = dut.mem[4] ^ 39'h100008;
    bus_op(1'b1, 32'h010, 4'hF, 32'h0, g_pre, g_post, rd, s, m);
    check("double multi_error", 64'(m), 64'd1);
    check("double single_error", 64'(s), 64'd0);
    dut.mem[4] = dut.mem[4] ^ 39'h100008;

    // Reset asserted in the RMW cycle of a be=0011 write.
    req = 1'b1; wen = 1'b0; add = 32'h010; be = 4'h3; wdata = 32'h00001111;
    @(posedge clk); #1;
    req = 1'b0; wen = 1'b1; be = 4'hF;
    check("rmw gnt low", 64'(gnt), 64'd0);
    rst_n = 1'b0;
    #1;
    check("reset in rmw gnt", 64'(gnt), 64'd1);
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("after reset gnt", 64'(gnt), 64'd1);
    check("aborted rmw stored", 64'(dut.mem[4]), 64'(tb_encode(32'hDEADBEAA)));
    bus_op(1'b1, 32'h010, 4'hF, 32'h0, g_pre, g_post, rd, s, m);
    check("aborted rmw rdata", 64'(rd), 64'hDEADBEAA);
    check("aborted rmw single_error", 64'(s), 64'd0);

    // Codeword bus: full write, byte-3 partial write, read back.
    bus_op_c(1'b0, 32'h008, 4'hF, tb_encode(32'h12345678), g_post, rd_c, s, m);
    check("ecc full write gnt next", 64'(g_post), 64'd1);
    bus_op_c(1'b0, 32'h008, 4'h8, tb_encode(32'hAB000000), g_post, rd_c, s, m);
    check("ecc partial gnt next", 64'(g_post), 64'd0);
    check("ecc partial single_error", 64'(s), 64'd0);
    bus_op_c(1'b1, 32'h008, 4'hF, 39'h0, g_post, rd_c, s, m);
    check("ecc read rdata", 64'(rd_c), 64'(tb_encode(32'hAB345678)));
    check("ecc read single_error", 64'(s), 64'd0);
    check("ecc read multi_error", 64'(m), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecc_word_sram.md
Name: ecc_word_sram

Overview:
- Single-port, word-addressed SRAM bank; every 32-bit word is stored as a 39-bit SECDED (Hsiao) codeword.
- Sits between a TCDM-style request/grant bus and the storage array.
- Corrects single-bit errors and detects double-bit errors on reads.
- Implements byte-enabled (partial) writes as a two-cycle read-modify-write (RMW).

Parameters:
- BankSize, 256: number of 39-bit words; BankAddWidth = $clog2(BankSize).
- InputECC, 0: 0 = bus carries 32-bit plain data; 1 = bus carries 39-bit codewords. DataWidth = InputECC ? 39 : 32.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- tcdm_req_i  in  1  request.
- tcdm_wen_i  in  1  1 = read, 0 = write.
- tcdm_add_i  in  32  byte address; only bits [BankAddWidth+1:2] are used.
- tcdm_be_i  in  4  byte enables, bit k covers data bits [8k+7:8k].
- tcdm_wdata_i  in  DataWidth  write data.
- tcdm_gnt_o  out  1  grant.
- tcdm_rdata_o  out  DataWidth  read data, valid one cycle after a granted read.
- single_error_o  out  1  corrected single-bit error on the previous access.
- multi_error_o  out  1  uncorrectable error on the previous access.

Behaviour:
- Code definition:
  - Codeword [31:0] = data, [38:32] = check bits.
  - Column of data bit j = the j-th 7-bit value (ascending numeric order) with popcount 3: 0x07, 0x0B, 0x0D, 0x0E, 0x13, …
  - Check bit i = XOR of the data bits whose column has bit i set.
  - Check bit i's own column = one-hot (1<<i).
- Decode:
  - Syndrome = recomputed check bits XOR stored check bits.
  - Zero syndrome: no error.
  - Odd-weight syndrome: single error; flip the bit whose column equals the syndrome (if none matches, data is unchanged); err = 01.
  - Even nonzero syndrome: err = 10; data is passed through uncorrected.
- State machine, two states: NORMAL and RMW. Reset state is NORMAL.
- In NORMAL:
  - tcdm_gnt_o = 1; memory req = tcdm_req_i; memory we = ~tcdm_wen_i; address taken from tcdm_add_i.
  - Write data = encode(tcdm_wdata_i) when InputECC=0; raw tcdm_wdata_i when InputECC=1.
  - A request with wen=0 and be != 4'b1111 is a partial write: the memory does a read instead (we=0) and the next state is RMW.
- Every cycle, the address index, wdata and be are registered unconditionally.
- In RMW (exactly one cycle):
  - tcdm_gnt_o = 0; memory req = 1, we = 1, address = registered address.
  - Merged word = (be-mask & new data) | (~be-mask & decoded read data). The be-mask expands each registered be bit to 8 bits.
  - New data = registered wdata (InputECC=0) or decode(registered wdata) (InputECC=1).
  - Stored value = encode(merged word).
  - Next state = NORMAL. Bus inputs present during RMW are ignored; the master holds its request because gnt=0.
- A partial write with be = 0000 still performs the RMW and rewrites the word unchanged.
- Read latency is 1 cycle.
  - tcdm_rdata_o = decoded, corrected data (InputECC=0) or the raw stored codeword (InputECC=1).
  - rdata is unspecified in cycles that do not follow a read.
- Error flags:
  - A registered valid_q = req & gnt & (wen | be != 1111), reset 0.
  - single_error_o = err[0] & valid_q; multi_error_o = err[1] & valid_q.
  - For both InputECC settings, err comes from decoding the memory read data.
  - Flags are combinational from the memory output and valid only in the cycle after the access.
- Reset values: state NORMAL, valid_q 0, all buffers 0, so the error flags are 0 and tcdm_gnt_o is 1.
- Memory contents are not reset. Simulation initialises the array to all zeros, which is a valid codeword.
- Reset asserted during RMW aborts the pending write.
- Out-of-range upper address bits are ignored (the address wraps modulo BankSize).
- The simulation-only $display of error events is optional.

Decomposition:
- Package ecc_word_sram_pkg holds:
  - constants DataW=32, CodeW=39, ChkW=7;
  - a function returning the 7-bit column for data bit j;
  - the enum type for the states.
- Sub-module hsiao_39_32_codec:
  - purely combinational;
  - encode port: data in → codeword out;
  - decode port: codeword in → corrected data and err[1:0] out.
  - Instantiate it once per required encode/decode path.
- The storage array and its read register are inline (1-cycle registered read, single port).

Test Plan:
- Full write of 0xDEADBEEF at address 0x10, then read 0x10 → gnt=1 throughout; rdata = 0xDEADBEEF one cycle later; both error flags 0.
- Partial write be=0001, wdata=0x000000AA at 0x10 → gnt=0 in the following cycle; a subsequent read returns 0xDEADBEAA.
- Backdoor flip of stored bit 5 at 0x10, then read → rdata = 0xDEADBEAA; single_error_o=1 for one cycle; multi_error_o=0.
- Backdoor flip of bits 3 and 20, then read → multi_error_o=1; single_error_o=0.
- Assert rst_ni low during the RMW cycle of a be=0011 write → state returns to NORMAL, the word is unchanged, and gnt=1 after reset.
- InputECC=1: write the codeword of 0x12345678, then partial write be=1000 with the codeword of 0xAB000000 → read returns the codeword of 0xAB345678 and no error flags.
